// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch stage.
// Owns the program counter and issues word-aligned fetches over a req/gnt/rvalid port, with at
// most one request in flight. Responses go into a small FIFO that feeds ID. A redirect from ID
// flushes the FIFO, toggles the fetch epoch and reloads the PC, so any response still in flight
// at that point is dropped when it arrives.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   redirect_pc/_we       branch/jump target from ID and its take strobe
//   imem_req/addr         fetch request and word-aligned address (addr = pc)
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     response strobe and instruction word
//   id_valid/ready        handshake toward ID, transfer on valid && ready
//   id_pc/id_instr        FIFO head: PC and instruction word
//   misalign              sticky misaligned-redirect flag
//
// Build option
//   IF_MISALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned target sets misalign
//                         and stops fetching until the next aligned redirect or reset. When
//                         undefined, the low two target bits are ignored and misalign is 0.

`ifndef SYS_ADDR_SPACE
`define SYS_ADDR_SPACE 32
`endif

module pc_fetch_unit #(
  parameter logic [`SYS_ADDR_SPACE-1:0] RESET_PC   = '0,
  parameter int unsigned                FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [`SYS_ADDR_SPACE-1:0] redirect_pc,
  input  logic                       redirect_we,
  output logic                       imem_req,
  output logic [`SYS_ADDR_SPACE-1:0] imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [`SYS_ADDR_SPACE-1:0] id_pc,
  output logic [31:0]                id_instr,
  output logic                       misalign
);

  localparam int unsigned AW = `SYS_ADDR_SPACE;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [AW-1:0] PcStep = AW'(4);
  localparam logic [PW-1:0] PtrOne = PW'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntMax = CW'(FIFO_DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          run_q;
  logic          outstanding_q, outstanding_d;
  logic          epoch_q, epoch_d;
  logic          req_epoch_q, req_epoch_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic          halted;
  logic [AW-1:0] target_pc;
  logic          resp_done;
  logic          push;
  logic          pop;
  logic          fire;
  logic [CW-1:0] reserved;

  assign target_pc = {redirect_pc[AW-1:2], 2'b00};

  // Only a response to our own outstanding request counts; stray rvalid is ignored.
  assign resp_done = imem_rvalid && outstanding_q;
  assign push      = resp_done && (req_epoch_q == epoch_q) && !redirect_we;

  // FIFO slots are reserved at issue time, so a granted response always has room.
  assign reserved  = count_q + {{(CW-1){1'b0}}, outstanding_q};

  // run_q holds the request low for the first cycle out of reset.
  assign imem_req  = run_q && (!outstanding_q || imem_rvalid) && (reserved < CntMax) &&
                     !redirect_we && !halted;
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_gnt;

  assign id_valid  = (count_q != '0) && !redirect_we;
  assign pop       = id_valid && id_ready;
  assign id_pc     = fifo_pc_q[rd_ptr_q];
  assign id_instr  = fifo_instr_q[rd_ptr_q];

  always_comb begin
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    outstanding_d = outstanding_q;
    req_pc_d      = req_pc_q;
    req_epoch_d   = req_epoch_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect_we) begin
      pc_d    = target_pc;
      epoch_d = ~epoch_q;
    end else if (fire) begin
      pc_d = pc_q + PcStep;
    end

    if (fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = pc_q;
      req_epoch_d   = epoch_q;
    end else if (resp_done) begin
      outstanding_d = 1'b0;
    end else if (redirect_we && outstanding_q) begin
      // Pin the in-flight tag to the opposite of the new epoch so that an even number of
      // back-to-back redirects cannot make a wrong-path response look current again.
      req_epoch_d = ~epoch_d;
    end

    if (redirect_we) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop) begin
        count_d = count_q + CntOne;
      end else if (pop && !push) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      run_q         <= 1'b0;
      outstanding_q <= 1'b0;
      epoch_q       <= 1'b0;
      req_pc_q      <= '0;
      req_epoch_q   <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      epoch_q       <= epoch_d;
      req_pc_q      <= req_pc_d;
      req_epoch_q   <= req_epoch_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_we) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  // Fetch stays stopped for exactly as long as the flag is set.
  assign halted   = misalign_q;
  assign misalign = misalign_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign halted              = 1'b0;
  assign misalign            = 1'b0;
`endif

endmodule
